// File: rtl/v_hier_subdeser_pkg.sv
// Shared types for the one-bit serial link receive path: FSM states and counter sizing.
// No logic, no latency, no backpressure of its own.
package v_hier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Bits needed to hold a bit count from 0 up to and including width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/v_hier_subdeser_if.sv
// Bit-in / word-out bundle of the serial deserializer.
// Both sides are valid/ready; the deserializer owns bit_ready, word_valid, word_data and sync_err.
// Backpressure: bit_ready toward the bit source, word_ready from the word sink.
interface v_hier_subdeser_if #(
    parameter int WIDTH = 8
);
    logic                    bit_valid;
    logic signed             bit_in;
    logic                    frame_start;
    logic                    bit_ready;
    logic                    word_valid;
    logic signed [WIDTH-1:0] word_data;
    logic                    word_ready;
    logic                    sync_err;

    modport master (
        output bit_valid, bit_in, frame_start, word_ready,
        input  bit_ready, word_valid, word_data, sync_err
    );

    modport slave (
        input  bit_valid, bit_in, frame_start, word_ready,
        output bit_ready, word_valid, word_data, sync_err
    );
endinterface

// File: rtl/v_hier_subdeser_wordreg.sv
// One-entry valid/ready output register holding an assembled word.
// Latency: a load is visible the cycle after i_load; backpressure: holds data while !i_ready.
// o_free reports the slot can take a load this edge (empty, or being drained now).
module v_hier_wordreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_free
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_free  = !r_valid || i_ready;

    // A load on the same edge as a drain wins, so the slot never bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/v_hier_subdeser.sv
// Serial-to-word deserializer: framed single bits in, WIDTH-bit words out, sticky framing error.
// Latency: word_valid the cycle after the last bit when the output slot is free.
// Backpressure: a completed word waits in the shift register (FULL) and bit_ready drops until it moves.
module v_hier_subdeser
    import v_hier_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    v_hier_subdeser_if.slave bus
);
    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
    logic             r_sync_err, w_err_set;
    logic             w_bit_xfer, w_word_xfer, w_out_free, w_load;
    logic [WIDTH-1:0] w_load_dat, w_word_dat;

    assign bus.bit_ready = (r_state != FULL);
    assign bus.sync_err  = r_sync_err;
    assign bus.word_data = w_word_dat;
    assign w_bit_xfer    = bus.bit_valid && bus.bit_ready;
    assign w_word_xfer   = bus.word_valid && bus.word_ready;

    // After WIDTH shifts every stale bit has left the register, so no clear on frame start.
    assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], bus.bit_in}
                                 : {bus.bit_in, r_shift[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_err_set   = 1'b0;
        w_load      = 1'b0;
        w_load_dat  = w_shifted;
        case (r_state)
            IDLE: begin
                if (w_bit_xfer) begin
                    if (bus.frame_start) begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = ONE_CNT;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (w_bit_xfer) begin
                    // A restart beats completion even on the final bit position.
                    if (bus.frame_start) begin
                        w_err_set   = 1'b1;
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = ONE_CNT;
                    end else if (r_cnt == LAST_CNT) begin
                        if (w_out_free) begin
                            w_load      = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_shift_nxt = w_shifted;
                            w_cnt_nxt   = FULL_CNT;
                            w_state_nxt = FULL;
                        end
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (w_word_xfer) begin
                    w_load      = 1'b1;
                    w_load_dat  = r_shift;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_sync_err <= r_sync_err || w_err_set;
        end
    end

    v_hier_wordreg #(.WIDTH(WIDTH)) u_wordreg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_data  (w_load_dat),
        .i_ready (bus.word_ready),
        .o_valid (bus.word_valid),
        .o_data  (w_word_dat),
        .o_free  (w_out_free)
    );
endmodule

// File: doc/v_hier_subdeser.md
Name: v_hier_subdeser

Overview:
- Receiving end of the one-bit signed serial link.
- Accepts a framed stream of single signed bits (one per valid cycle), assembles WIDTH-bit signed words, and presents them on a one-entry valid/ready output.
- Sits below a v_hier_sub-level wrapper, consuming the bit that the pass-through leaf drives.
- Provides back-pressure toward the bit source and sticky framing-error reporting.

Parameters:
- WIDTH, 8: bits per assembled word; legal range 2..32.
- MSB_FIRST, 1: 1 means the first bit of a frame is word bit WIDTH-1; 0 means it is bit 0.

Ports:
- clk  input  1  Sole clock; all state updates on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- bit_valid  input  1  bit_in and frame_start are valid this cycle.
- bit_in  input  1 (signed)  Serial data bit.
- frame_start  input  1  Qualified by bit_valid; marks the first bit of a word.
- bit_ready  output  1  Block accepts a bit this cycle. A transfer occurs when bit_valid && bit_ready.
- word_valid  output  1  word_data holds a complete word.
- word_data  output  WIDTH (signed)  Assembled word.
- word_ready  input  1  Downstream accepts. A transfer occurs when word_valid && word_ready.
- sync_err  output  1  Sticky framing error; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high, overrides everything): state=IDLE, bit count=0, shift register=0, word_valid=0, word_data=0, sync_err=0, bit_ready=1.
- States: IDLE, SHIFT, FULL.
- IDLE:
  - A bit transfer with frame_start=1 stores the bit as the first bit, sets count=1 and moves to SHIFT.
  - A bit transfer with frame_start=0 discards the bit, sets sync_err, and stays in IDLE.
- SHIFT:
  - Each bit transfer with frame_start=0 stores the bit and increments count.
  - Bit order follows MSB_FIRST: shift left with the bit entering at bit 0, or shift right with the bit entering at bit WIDTH-1.
  - A bit transfer with frame_start=1 abandons the partial word, sets sync_err, treats that bit as the first bit of a new frame (count=1), and stays in SHIFT.
  - Completion: the transfer that brings count to WIDTH completes the word.
    - If the output register is free this cycle (word_valid=0, or a word transfer is happening now), load word_data and set word_valid=1 on the next edge. Go to IDLE with count=0.
    - Otherwise hold the completed word in the shift register and go to FULL.
- FULL:
  - bit_ready=0, so no bits are accepted.
  - On a word transfer, load the held word into word_data with word_valid staying 1, and go to IDLE. bit_ready=1 in the cycle after.
- bit_ready=1 in IDLE and SHIFT.
- Latency: the last bit accepted at edge N gives word_valid=1 after edge N, when the output register is free.
- Throughput: back-to-back frames with no idle bits are sustained while word_ready=1 (one word per WIDTH cycles).
- word_valid falls after a word transfer edge unless a new word loads on that same edge.
- word_data is stable while word_valid=1 and word_ready=0.
- Simultaneous events:
  - A word transfer and word completion on the same edge load the new word with no bubble.
  - frame_start on the completing bit position in SHIFT takes restart priority over completion.
- Width rules:
  - word_data is a bit-exact copy of the received bits; no sign extension inside the word.
  - The count register is $clog2(WIDTH+1) bits and never wraps beyond WIDTH.
- Reset asserted mid-frame or in FULL discards all partial and held data; no word_valid pulse follows.

Decomposition:
- Shared package v_hier_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, FULL=2'd2);
  - count-width function.
- Natural sub-module v_hier_wordreg: one-entry valid/ready output register with load and accept.
- The deserializer FSM and shift register live in the top.

Test Plan:
- WIDTH=8, MSB_FIRST=1, word_ready=1; send frame bits 1,0,1,1,0,0,1,0 -> word_data=8'shB2 (-78) with word_valid=1 exactly one cycle after the 8th bit; sync_err=0.
- MSB_FIRST=0, same bit sequence -> word_data=8'sh4D.
- Two back-to-back frames 8'hFF then 8'h01 with word_ready=1 -> two word_valid pulses 8 cycles apart; bit_ready stays 1 throughout.
- word_ready=0 held; send three frames -> first word held on output, second frame completes into FULL, bit_ready=0. Raise word_ready for 1 cycle -> second word appears, FULL exits, bit_ready=1 next cycle; third frame then assembles normally.
- Send 3 bits, then frame_start with 8 more bits 0x80 -> sync_err=1; single word 8'sh80 (-128); abandoned partial bits never appear.
- Stray bit with frame_start=0 in IDLE -> sync_err=1, no word. Then assert reset mid-frame -> all outputs 0 next cycle, sync_err=0, no word_valid until a fresh complete frame.
